// File: rtl/multi_button_processor.sv
`timescale 1ns/1ps
// multi_button_processor: N_CH independent pushbutton channels, each with a
// two-flop synchroniser, a counting debouncer and a short/long press
// classifier with optional auto-repeat. Outputs are one-cycle registered pulses.
module multi_button_processor #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 2000,
  parameter int unsigned REPEAT_EN   = 0,
  parameter int unsigned REPEAT_MS   = 500,
  parameter int unsigned CNT_W       = 12
) (
  input  logic            clk_1khz,
  input  logic            rst_i,
  input  logic [N_CH-1:0] pushbutton_i,
  output logic [N_CH-1:0] count_up,
  output logic [N_CH-1:0] count_down
);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_e;

  // Debounced level toggles when the mismatch counter holds this value.
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_MS - 1);
  // The press timer is 0 in the first cycle after deb rises, so its
  // incremented value hits LONG_MS-1 in the cycle before the event cycle.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

  // Timers stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    state_e           state_q;
    logic [CNT_W-1:0] timer_q, timer_inc;
    logic             up_q, down_q;

    assign timer_inc = sat_inc(timer_q);

    // Debounce next-state: count consecutive cycles of disagreement.
    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          deb_d = ~deb_q;
        end else begin
          deb_cnt_d = sat_inc(deb_cnt_q);
        end
      end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk_1khz) begin
      // NOTE: state uses non-blocking assignments so every flop samples
      // pre-edge values; sync1_q -> sync2_q depends on that ordering.
      if (rst_i) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        deb_q     <= 1'b0;
        deb_cnt_q <= '0;
      end else begin
        sync1_q   <= pushbutton_i[g];
        sync2_q   <= sync1_q;
        deb_q     <= deb_d;
        deb_cnt_q <= deb_cnt_d;
      end
    end

    // Press classifier with registered one-cycle event pulses.
    always_ff @(posedge clk_1khz) begin
      if (rst_i) begin
        state_q <= S_IDLE;
        timer_q <= '0;
        up_q    <= 1'b0;
        down_q  <= 1'b0;
      end else begin
        up_q   <= 1'b0;
        down_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            if (deb_q) begin
              state_q <= S_PRESSED;
              timer_q <= '0;
            end
          end
          S_PRESSED: begin
            if (!deb_q) begin
              up_q    <= 1'b1;
              state_q <= S_IDLE;
              timer_q <= '0;
            end else if (timer_inc == LONG_LAST) begin
              down_q  <= 1'b1;
              state_q <= S_HELD;
              timer_q <= '0;
            end else begin
              timer_q <= timer_inc;
            end
          end
          S_HELD: begin
            if (!deb_q) begin
              state_q <= S_IDLE;
              timer_q <= '0;
            end else if (REPEAT_EN != 0) begin
              if (timer_q == REPEAT_LAST) begin
                down_q  <= 1'b1;
                timer_q <= '0;
              end else begin
                timer_q <= timer_inc;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            timer_q <= '0;
          end
        endcase
      end
    end

    assign count_up[g]   = up_q;
    assign count_down[g] = down_q;
  end

endmodule

// File: doc/multi_button_processor.md
# multi_button_processor

Parametrised, multi-channel successor to the single-button processor in the scoreboard front end. It runs on the 1 kHz system tick and serves N_CH asynchronous pushbuttons. Each channel is synchronised and debounced, then classified as a short press (one `count_up` pulse on release) or a long press (one `count_down` pulse once the hold threshold is reached). An optional auto-repeat mode issues further `count_down` pulses while the button stays held. Its outputs drive the score counters directly.

## Interface
- `N_CH`, 2, number of independent button channels (≥1)
- `DEBOUNCE_MS`, 20, consecutive clock cycles a new level must persist before it is accepted (≥1)
- `LONG_MS`, 2000, cycles from debounced press to the long-press event (> `DEBOUNCE_MS`)
- `REPEAT_EN`, 0, 1 = emit repeated `count_down` pulses while held after a long press
- `REPEAT_MS`, 500, repeat period in cycles (≥1; ignored when `REPEAT_EN`=0)
- `CNT_W`, 12, width of the per-channel timers; must satisfy 2^CNT_W > max(`LONG_MS`, `REPEAT_MS`, `DEBOUNCE_MS`)

- `clk_1khz` in 1 — system clock, 1 kHz
- `rst_i` in 1 — reset; one clock, synchronous, active-high
- `pushbutton_i` in N_CH — raw asynchronous buttons, 1 = pressed
- `count_up` out N_CH — one-cycle pulse per short press, per channel
- `count_down` out N_CH — one-cycle pulse per long press and per repeat, per channel

## Operation
- Channels are fully independent. Simultaneous activity on several channels is handled in parallel.
- Synchroniser: two flip-flops per channel, reset to 0.
- Debouncer:
  - Holds a stable level `deb`, reset 0, and a counter, reset 0.
  - When the synchronised input equals `deb`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_MS`-1, `deb` toggles and the counter clears.
  - A bounce shorter than `DEBOUNCE_MS` cycles never changes `deb`.
- Classifier FSM per channel, states IDLE, PRESSED, HELD; reset to IDLE with timer 0.
  - IDLE: on `deb` rise → PRESSED, timer ← 0.
  - PRESSED: timer increments each cycle.
    - If `deb` falls first → `count_up` pulse in that cycle, then → IDLE.
    - If timer reaches `LONG_MS`-1 with `deb` still 1 → `count_down` pulse, → HELD, timer ← 0.
  - HELD, `REPEAT_EN`=1: timer increments. On reaching `REPEAT_MS`-1 → `count_down` pulse, timer ← 0.
  - HELD, `REPEAT_EN`=0: timer frozen, no pulses.
  - HELD: `deb` fall → IDLE, no pulse.
- A press never produces both `count_up` and `count_down`.
- Timers saturate and never wrap.
- Reset mid-press: all state clears to IDLE and `deb`=0. If the button is still held after reset, it is treated as a fresh press after full debounce and synchroniser latency.

## Timing
- All outputs are 0 during and after reset until a classified event occurs. Outputs are registered.
- `deb` rises `DEBOUNCE_MS`+2 cycles after a clean input rise: 2 synchroniser cycles plus the debounce count.
- Let t0 be the cycle `deb` rises:
  - `count_down` is high at t0+`LONG_MS`.
  - With `REPEAT_EN`=1, repeats are high at t0+`LONG_MS`+k·`REPEAT_MS`, k≥1, while `deb` stays 1.
- Short press: `count_up` is high in the cycle after `deb` falls, provided `deb` was 1 for fewer than `LONG_MS` cycles.
- Every pulse is exactly one cycle wide. Back-to-back presses need a full debounce on each edge.

## Test plan
- Bounce then short press: defaults; toggle channel 0 at 1/2/2/1/2 ms, then hold 30 ms and release → exactly one `count_up[0]` pulse after release; no `count_down`; no pulse during the bounces.
- Long press: hold channel 0 for 2.1 s → one `count_down[0]` pulse at t0+2000 cycles; no `count_up` on release.
- Auto-repeat: `REPEAT_EN`=1, `REPEAT_MS`=500; hold 3.2 s → `count_down` pulses at t0+2000, 2500, 3000 cycles, then none after release.
- Channel independence: `N_CH`=4; press ch1 short and ch2 long over overlapping windows → only `count_up[1]` and `count_down[2]` pulse; ch0 and ch3 stay 0.
- Threshold boundary: `deb` high for 1999 cycles → one `count_up`; high for 2000 cycles → one `count_down` and no `count_up`.
- Reset mid-press: assert `rst_i` for one cycle 1 s into a hold while the button stays pressed → no outputs from the pre-reset press; `count_down` occurs 2000 cycles after the post-reset `deb` rise, which is 22 cycles after reset.
